// File: rtl/jk_pkg.sv
// Purpose : shared types and constants for the JK excitation driver.
// Latency : n/a (types, constants and one combinational helper).
// Backpr. : n/a.
// Contents: FSM state enum, 2-bit {J,K} command codes, mismatch counter width,
//           and jk_cmd(), which maps one target/model bit pair to a command.
// Build option: define JK_TOGGLE_EN to drive every changed bit as a toggle (11)
//           instead of the default set (10) / reset (01) encoding.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } jk_state_e;

  // Commands are packed as {J,K}.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam int MISM_W = 8;

  function automatic logic [1:0] jk_cmd(input logic tgt, input logic cur);
    logic [1:0] cmd;
    if (tgt == cur) begin
      cmd = JK_HOLD;
    end
`ifdef JK_TOGGLE_EN
    else begin
      cmd = JK_TGL;
    end
`else
    else if (tgt) begin
      cmd = JK_SET;
    end else begin
      cmd = JK_RST;
    end
`endif
    return cmd;
  endfunction

endpackage

// File: rtl/jk_excitation_driver_fifo.sv
// Purpose : DEPTH x WIDTH target FIFO (module jk_tgt_fifo) with full/empty flags.
// Latency : a pushed word is visible on head the cycle after the push.
// Backpr. : pushes while full and pops while empty are ignored.
// Ports   : clk, reset (sync, active-high); push/push_data write side;
//           pop/head read side (head is show-ahead); full, empty flags.
module jk_tgt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Purpose : queues target Q words and drives registered J/K excitation to move
//           downstream JK flip-flops from the modelled Q to each target, then
//           checks their feedback and keeps a sticky error and mismatch count.
// Latency : target into an empty FIFO while idle appears on j/k 2 cycles after
//           acceptance; one target per 3+HOLD_CYCLES cycles.
// Backpr. : tgt_ready = !full (a same-cycle pop does not open a slot).
// Ports   : clk, reset (sync, active-high); tgt_valid/tgt_data/tgt_ready target
//           input; q_fb downstream Q feedback; err_clr; j, k, exc_valid command
//           output; busy, err, mism_cnt status.
// Build option: JK_TOGGLE_EN (see jk_pkg) selects toggle encoding.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tgt_valid,
  input  logic [WIDTH-1:0]  tgt_data,
  output logic              tgt_ready,
  input  logic [WIDTH-1:0]  q_fb,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  j,
  output logic [WIDTH-1:0]  k,
  output logic              exc_valid,
  output logic              busy,
  output logic              err,
  output logic [MISM_W-1:0] mism_cnt
);

  localparam logic [3:0] HOLD_LOAD = 4'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  jk_state_e        state;
  logic [WIDTH-1:0] q_model;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic [3:0]       hold_cnt;
  logic             full;
  logic             empty;
  logic             pop;
  logic             mism;

  assign tgt_ready = !full;
  assign pop       = (state == ST_IDLE) && !empty;
  assign busy      = (state != ST_IDLE) || !empty;
  assign mism      = (state == ST_CHECK) && (q_fb != q_model);

  jk_tgt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tgt_valid),
    .push_data (tgt_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Command for the head word relative to what the flops currently hold.
  always_comb begin
    j_nxt = '0;
    k_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j_nxt[i], k_nxt[i]} = jk_cmd(head[i], q_model[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      q_model   <= '0;
      j         <= '0;
      k         <= '0;
      exc_valid <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      // j/k are only non-zero for the single DRIVE cycle.
      j         <= '0;
      k         <= '0;
      exc_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            j         <= j_nxt;
            k         <= k_nxt;
            exc_valid <= 1'b1;
            q_model   <= head;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: state <= ST_CHECK;
        ST_CHECK: begin
          if (HOLD_CYCLES > 0) begin
            hold_cnt <= HOLD_LOAD;
            state    <= ST_HOLD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 4'd0) state <= ST_IDLE;
          else                  hold_cnt <= hold_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A new mismatch wins over a same-cycle clear; the count is never cleared
  // by err_clr and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      mism_cnt <= '0;
    end else begin
      if (mism)         err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (mism && (mism_cnt != '1)) mism_cnt <= mism_cnt + MISM_W'(1);
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;

  localparam int W = 4;
`ifdef JK_TOGGLE_EN
  localparam bit TGL = 1'b1;
`else
  localparam bit TGL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset     = 1'b1;
  logic         sel       = 1'b0;   // 0: HOLD_CYCLES=0 instance, 1: HOLD_CYCLES=3 instance
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_data  = '0;
  logic         err_clr   = 1'b0;
  logic         force_fb  = 1'b0;   // forces feedback to 0000

  logic         v         [2];
  logic [W-1:0] q_ff      [2];
  logic [W-1:0] q_fb      [2];
  logic [W-1:0] j         [2];
  logic [W-1:0] k         [2];
  logic         tgt_ready [2];
  logic         exc_valid [2];
  logic         busy      [2];
  logic         err       [2];
  logic [7:0]   mism_cnt  [2];

  assign v[0]    = tgt_valid && !sel;
  assign v[1]    = tgt_valid && sel;
  assign q_fb[0] = force_fb ? '0 : q_ff[0];
  assign q_fb[1] = force_fb ? '0 : q_ff[1];

  jk_excitation_driver #(.WIDTH(W), .DEPTH(4), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .tgt_valid(v[0]), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready[0]), .q_fb(q_fb[0]), .err_clr(err_clr),
    .j(j[0]), .k(k[0]), .exc_valid(exc_valid[0]), .busy(busy[0]),
    .err(err[0]), .mism_cnt(mism_cnt[0]));

  jk_excitation_driver #(.WIDTH(W), .DEPTH(4), .HOLD_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .tgt_valid(v[1]), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready[1]), .q_fb(q_fb[1]), .err_clr(err_clr),
    .j(j[1]), .k(k[1]), .exc_valid(exc_valid[1]), .busy(busy[1]),
    .err(err[1]), .mism_cnt(mism_cnt[1]));

  // Downstream JK flip-flops: Q+ = J&~Q | ~K&Q.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) q_ff[i] <= '0;
      else       q_ff[i] <= (j[i] & ~q_ff[i]) | (~k[i] & q_ff[i]);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] j;
    logic [W-1:0] k;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: every command cycle is compared with the oldest expectation.
  always @(negedge clk) begin
    if (exc_valid[0] || exc_valid[1]) begin
      int   s;
      exp_t e;
      s = exc_valid[1] ? 1 : 0;
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("jk_cmd", {24'd0, j[s], k[s]}, {24'd0, e.j, e.k});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers d (valid stays high afterwards) and returns one cycle after acceptance.
  task automatic push(input logic [W-1:0] d, input logic [W-1:0] ej,
                      input logic [W-1:0] ek, input bit expect_it);
    int   t;
    exp_t e;
    t = 0;
    tgt_valid = 1'b1;
    tgt_data  = d;
    while (!tgt_ready[sel] && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) timeout("ready_wait");
    if (expect_it) begin
      e.j = ej;
      e.k = ek;
      exp_q.push_back(e);
    end
    tick();
  endtask

  // Push with expectations for the default (dj/dk) and toggle (tj/tk) builds.
  task automatic pv(input logic [W-1:0] d, input logic [W-1:0] dj, input logic [W-1:0] dk,
                    input logic [W-1:0] tj, input logic [W-1:0] tk);
    if (TGL) push(d, tj, tk, 1'b1);
    else     push(d, dj, dk, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    tgt_valid = 1'b0;
    while ((busy[sel] || exp_q.size() != 0) && t < 400) begin
      tick();
      t++;
    end
    if (t >= 400) timeout("drain");
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", tgt_ready[i], 1);
      check("rst_busy",  busy[i], 0);
      check("rst_exc",   exc_valid[i], 0);
      check("rst_jk",    {j[i], k[i]}, 0);
      check("rst_err",   err[i], 0);
      check("rst_cnt",   mism_cnt[i], 0);
    end

    // First target, latency and single-cycle pulse.
    sel = 1'b0;
    pv(4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010);
    tgt_valid = 1'b0;
    check("lat_c1_exc",  exc_valid[0], 0);
    check("lat_c1_busy", busy[0], 1);
    tick();
    check("lat_c2_exc", exc_valid[0], 1);
    tick();
    check("pulse_1cyc", exc_valid[0], 0);
    drain();
    check("match_err", err[0], 0);
    check("match_cnt", mism_cnt[0], 0);

    pv(4'b0110, 4'b0100, 4'b1000, 4'b1100, 4'b1100);  drain();
    pv(4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);  drain();
    pv(4'b1001, 4'b1001, 4'b0110, 4'b1111, 4'b1111);  drain();
    check("seq_err", err[0], 0);

    // Back-to-back burst, 3 cycles between commands.
    pulse_cyc.delete();
    pv(4'b0011, 4'b0010, 4'b1000, 4'b1010, 4'b1010);
    pv(4'b1111, 4'b1100, 4'b0000, 4'b1100, 4'b1100);
    pv(4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111);
    pv(4'b0101, 4'b0101, 4'b0000, 4'b0101, 4'b0101);
    pv(4'b1100, 4'b1000, 4'b0001, 4'b1001, 4'b1001);
    drain();
    check("burst_n", pulse_cyc.size(), 5);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check("burst_gap", pulse_cyc[i] - pulse_cyc[i-1], 3);

    // Forced mismatch, then clear.
    force_fb = 1'b1;
    pv(4'b1111, 4'b0011, 4'b0000, 4'b0011, 4'b0011);
    drain();
    force_fb = 1'b0;
    check("mm_err", err[0], 1);
    check("mm_cnt", mism_cnt[0], 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err", err[0], 0);
    check("clr_cnt", mism_cnt[0], 1);

    // Mismatch and clear in the same cycle: set wins.
    force_fb = 1'b1;
    err_clr  = 1'b1;
    pv(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tgt_valid = 1'b0;
    repeat (3) tick();
    check("setclr_err", err[0], 1);
    check("setclr_cnt", mism_cnt[0], 2);
    tick();
    check("clr_after", err[0], 0);
    err_clr = 1'b0;

    // Saturation: 298 more mismatches, 300 in total.
    for (int n = 0; n < 298; n++) pv(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drain();
    force_fb = 1'b0;
    check("sat_cnt", mism_cnt[0], 255);
    check("sat_err", err[0], 1);

    // Reset during DRIVE discards the queue and the model.
    pv(4'b0001, 4'b0000, 4'b1110, 4'b1110, 4'b1110);
    push(4'b0010, 4'b0000, 4'b0000, 1'b0);
    check("drv_exc", exc_valid[0], 1);
    tgt_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("drvrst_jk",    {j[0], k[0]}, 0);
    check("drvrst_exc",   exc_valid[0], 0);
    check("drvrst_busy",  busy[0], 0);
    check("drvrst_ready", tgt_ready[0], 1);
    reset = 1'b0;
    tick();
    check("drvrst_err", err[0], 0);
    check("drvrst_cnt", mism_cnt[0], 0);
    pv(4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010);
    drain();

    // Reset during CHECK records no mismatch.
    force_fb = 1'b1;
    pv(4'b0101, 4'b0101, 4'b1010, 4'b1111, 4'b1111);
    tgt_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    force_fb = 1'b0;
    tick();
    check("chkrst_cnt", mism_cnt[0], 0);
    check("chkrst_err", err[0], 0);

    // HOLD_CYCLES=3 instance: fill while stalled, 6 cycles between commands.
    sel = 1'b1;
    pulse_cyc.delete();
    pv(4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    pv(4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0010);
    check("fill_rdy1", tgt_ready[1], 1);
    pv(4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b0101);
    check("fill_rdy2", tgt_ready[1], 1);
    pv(4'b1100, 4'b1000, 4'b0010, 4'b1010, 4'b1010);
    check("fill_rdy3", tgt_ready[1], 1);
    pv(4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0100);
    check("fill_rdy4", tgt_ready[1], 0);
    pv(4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000);
    drain();
    check("hold_n", pulse_cyc.size(), 6);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check("hold_gap", pulse_cyc[i] - pulse_cyc[i-1], 6);
    check("hold_err", err[1], 0);

    check("leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
